// File: rtl/l2c_ifmap_fetch_arb.sv
// Fills the ifmap FIFOs from the GLB: round-robin among enabled, non-full FIFOs, one byte read outstanding.
// Byte period is at least 3 cycles (ARB, REQ, WAIT); push is combinational with rvalid; fifo_reset_i aborts.
module l2c_ifmap_fetch_arb #(
  parameter int NUM_FIFO = 32,
  parameter int LEN_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_reset_i,
  input  logic [NUM_FIFO-1:0][31:0] base_addr_i,
  input  logic                     fetch_start_i,
  input  logic [LEN_W-1:0]         fetch_len_i,
  input  logic [NUM_FIFO-1:0]      fifo_en_i,
  input  logic [NUM_FIFO-1:0]      fifo_full_i,
  output logic                     glb_rd_req_o,
  output logic [31:0]              glb_rd_addr_o,
  input  logic                     glb_rd_gnt_i,
  input  logic                     glb_rd_rvalid_i,
  input  logic [7:0]               glb_rd_data_i,
  output logic [NUM_FIFO-1:0]      fifo_push_o,
  output logic [7:0]               fifo_push_data_o,
  output logic                     busy_o,
  output logic                     fetch_done_o
);

  localparam int SEL_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [31:0]         base_q   [NUM_FIFO];
  logic [LEN_W-1:0]    offset_q [NUM_FIFO];
  logic [LEN_W-1:0]    remain_q [NUM_FIFO];
  logic [SEL_W-1:0]    rr_ptr, sel;

  logic [NUM_FIFO-1:0] pending, eligible;
  logic [SEL_W-1:0]    pick;
  logic                pick_vld;
  logic [SEL_W:0]      scan_idx;
  logic                byte_done;

  assign byte_done = (state == S_WAIT) && glb_rd_rvalid_i;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_FIFO; i++) pending[i] = |remain_q[i];
    eligible = pending & ~fifo_full_i;
  end

  // First eligible FIFO at or after rr_ptr, scanning with wrap.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (scan_idx >= (SEL_W+1)'(NUM_FIFO)) scan_idx = scan_idx - (SEL_W+1)'(NUM_FIFO);
      if (!pick_vld && eligible[scan_idx[SEL_W-1:0]]) begin
        pick     = scan_idx[SEL_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fetch_start_i) state_nxt = S_ARB;
      S_ARB: begin
        if (pending == '0) state_nxt = S_DONE;
        else if (pick_vld) state_nxt = S_REQ;
      end
      S_REQ:  if (glb_rd_gnt_i) state_nxt = S_WAIT;
      S_WAIT: if (glb_rd_rvalid_i) state_nxt = S_ARB;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (fifo_reset_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      sel    <= '0;
      for (int i = 0; i < NUM_FIFO; i++) begin
        base_q[i]   <= '0;
        offset_q[i] <= '0;
        remain_q[i] <= '0;
      end
    end else if (fifo_reset_i) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FIFO; i++) begin
        offset_q[i] <= '0;
        remain_q[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_start_i) begin
            for (int i = 0; i < NUM_FIFO; i++) begin
              base_q[i]   <= base_addr_i[i];
              offset_q[i] <= '0;
              remain_q[i] <= fifo_en_i[i] ? fetch_len_i : '0;
            end
          end
        end
        S_ARB: if (pick_vld) sel <= pick;
        S_WAIT: begin
          if (glb_rd_rvalid_i) begin
            offset_q[sel] <= offset_q[sel] + LEN_W'(1);
            remain_q[sel] <= remain_q[sel] - LEN_W'(1);
            rr_ptr        <= (sel == SEL_W'(NUM_FIFO-1)) ? '0 : sel + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Address is a pure function of registered state, so it is stable through the whole REQ phase.
  always_comb begin
    busy_o           = (state != S_IDLE);
    glb_rd_req_o     = (state == S_REQ);
    fetch_done_o     = (state == S_DONE);
    glb_rd_addr_o    = '0;
    fifo_push_o      = '0;
    fifo_push_data_o = '0;
    if (state == S_REQ) glb_rd_addr_o = base_q[sel] + 32'(offset_q[sel]);
    if (byte_done) begin
      fifo_push_o[sel] = 1'b1;
      fifo_push_data_o = glb_rd_data_i;
    end
  end

endmodule

// File: tb/tb_l2c_ifmap_fetch_arb.sv
// Randomised bench for l2c_ifmap_fetch_arb with a cycle-level reference model and a GLB responder.
module tb_l2c_ifmap_fetch_arb;
  localparam int N  = 32;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fifo_reset_i = 1'b0;
  logic [N-1:0][31:0] base_addr_i = '0;
  logic              fetch_start_i = 1'b0;
  logic [LW-1:0]     fetch_len_i = '0;
  logic [N-1:0]      fifo_en_i = '0;
  logic [N-1:0]      fifo_full_i = '0;
  logic              glb_rd_gnt_i = 1'b0;
  logic              glb_rd_rvalid_i = 1'b0;
  logic [7:0]        glb_rd_data_i = '0;
  logic              glb_rd_req_o;
  logic [31:0]       glb_rd_addr_o;
  logic [N-1:0]      fifo_push_o;
  logic [7:0]        fifo_push_data_o;
  logic              busy_o;
  logic              fetch_done_o;

  l2c_ifmap_fetch_arb #(.NUM_FIFO(N), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_reset_i(fifo_reset_i), .base_addr_i(base_addr_i),
    .fetch_start_i(fetch_start_i), .fetch_len_i(fetch_len_i), .fifo_en_i(fifo_en_i),
    .fifo_full_i(fifo_full_i), .glb_rd_req_o(glb_rd_req_o), .glb_rd_addr_o(glb_rd_addr_o),
    .glb_rd_gnt_i(glb_rd_gnt_i), .glb_rd_rvalid_i(glb_rd_rvalid_i), .glb_rd_data_i(glb_rd_data_i),
    .fifo_push_o(fifo_push_o), .fifo_push_data_o(fifo_push_data_o), .busy_o(busy_o),
    .fetch_done_o(fetch_done_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 arbitrate, 2 request, 3 await data, 4 done.
  int          ph, rr, msel;
  int          rem [N];
  int          off [N];
  logic [31:0] mbase [N];

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (rem[idx] != 0 && !fifo_full_i[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; rr = 0; msel = 0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; off[i] = 0; mbase[i] = 0; end
    end else if (fifo_reset_i) begin
      ph = 0; rr = 0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; off[i] = 0; end
    end else begin
      case (ph)
        0: if (fetch_start_i) begin
             for (int i = 0; i < N; i++) begin
               mbase[i] = base_addr_i[i];
               rem[i]   = fifo_en_i[i] ? int'(fetch_len_i) : 0;
               off[i]   = 0;
             end
             ph = 1;
           end
        1: begin
             int total_rem, p;
             total_rem = 0;
             for (int i = 0; i < N; i++) total_rem += rem[i];
             p = model_pick();
             if (total_rem == 0) ph = 4;
             else if (p >= 0) begin msel = p; ph = 2; end
           end
        2: if (glb_rd_gnt_i) ph = 3;
        3: if (glb_rd_rvalid_i) begin
             off[msel] = (off[msel] + 1) % 65536;
             rem[msel] = rem[msel] - 1;
             rr = (msel + 1) % N;
             ph = 1;
           end
        default: ph = 0;
      endcase
    end
  end

  // GLB responder: grant after gt request cycles, return data rt cycles after the grant.
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  initial begin
    int rs, gc, rc, gt, rt;
    rs = 0; gc = 0; rc = 0; gt = 0; rt = 0;
    forever begin
      @(posedge clk); #1;
      glb_rd_gnt_i = 1'b0; glb_rd_rvalid_i = 1'b0; glb_rd_data_i = 8'($urandom);
      if (rs == 1) begin
        if (rc >= rt) begin glb_rd_rvalid_i = 1'b1; rs = 0; end
        else rc++;
      end else if (glb_rd_req_o) begin
        if (gc == 0) gt = int'($urandom_range(gmax, gmin));
        if (gc >= gt) begin
          glb_rd_gnt_i = 1'b1; rs = 1; rc = 0; gc = 0;
          rt = int'($urandom_range(rmax, rmin));
        end else gc++;
      end else gc = 0;
    end
  end

  int total = 0, bad = 0, cyc = 0, ts = 0;
  int done_cnt = 0, done_cyc = -1, req_run = 0;
  logic [31:0] addr_q [$];
  int          push_q [$];
  int          run_q  [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: compare DUT against the model at the falling edge, then step past the next rising edge.
  task automatic tick();
    logic [N-1:0] ep;
    @(negedge clk);
    cyc++;
    ep = '0;
    if (ph == 3 && glb_rd_rvalid_i) ep[msel] = 1'b1;
    chk("busy", 64'(busy_o), 64'(ph != 0));
    chk("req", 64'(glb_rd_req_o), 64'(ph == 2));
    chk("done", 64'(fetch_done_o), 64'(ph == 4));
    chk("push", 64'(fifo_push_o), 64'(ep));
    if (ph == 2) chk("addr", 64'(glb_rd_addr_o), 64'(mbase[msel] + 32'(off[msel])));
    if (ep != '0) chk("push_data", 64'(fifo_push_data_o), 64'(glb_rd_data_i));
    if (glb_rd_req_o) begin
      if (glb_rd_gnt_i) begin
        addr_q.push_back(glb_rd_addr_o); run_q.push_back(req_run + 1); req_run = 0;
      end else req_run++;
    end else req_run = 0;
    for (int i = 0; i < N; i++) if (fifo_push_o[i]) push_q.push_back(i);
    if (fetch_done_o) begin done_cnt++; done_cyc = cyc; end
    @(posedge clk); #1;
  endtask

  task automatic start_fetch(logic [N-1:0] en, logic [LW-1:0] len);
    fifo_en_i = en; fetch_len_i = len; fetch_start_i = 1'b1;
    ts = cyc + 1;
    tick();
    fetch_start_i = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    chk("idle_timeout", 64'(busy_o), 64'(0));
  endtask

  task automatic set_glb(int g0, int g1, int r0, int r1);
    gmin = g0; gmax = g1; rmin = r0; rmax = r1;
  endtask

  initial begin
    int a0, p0, d0, r0, n;
    logic [31:0] exp_addr [4];
    int          exp_push [4];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h101; exp_addr[3] = 32'h201;
    exp_push[0] = 0; exp_push[1] = 1; exp_push[2] = 0; exp_push[3] = 1;

    // Reset state
    tick(); tick();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_req", 64'(glb_rd_req_o), 64'(0));
    chk("rst_push", 64'(fifo_push_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Two FIFOs alternate, immediate grant and data
    base_addr_i[0] = 32'h100; base_addr_i[1] = 32'h200;
    set_glb(0, 0, 0, 0);
    a0 = addr_q.size(); p0 = push_q.size(); d0 = done_cnt;
    start_fetch(32'h3, 16'd2);
    wait_idle(200);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 64'(addr_q[a0+i]), 64'(exp_addr[i]));
      chk("t1_push", 64'(push_q[p0+i]), 64'(exp_push[i]));
    end
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'(1));
    chk("t1_done_cyc", 64'(done_cyc), 64'(ts + 14));

    // Delayed grant: request held 4 cycles
    set_glb(3, 3, 0, 2);
    a0 = addr_q.size(); p0 = push_q.size(); d0 = done_cnt; r0 = run_q.size();
    start_fetch(32'h1, 16'd3);
    wait_idle(200);
    chk("t2_run", 64'(run_q[r0]), 64'(4));
    chk("t2_addr0", 64'(addr_q[a0]), 64'(32'h100));
    chk("t2_addr2", 64'(addr_q[a0+2]), 64'(32'h102));
    chk("t2_npush", 64'(push_q.size() - p0), 64'(3));
    for (int i = 0; i < 3; i++) chk("t2_push_fifo", 64'(push_q[p0+i]), 64'(0));
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'(1));

    // FIFO0 full: FIFO1 served, then stall until released
    set_glb(0, 0, 0, 0);
    fifo_full_i = 32'h1;
    p0 = push_q.size(); d0 = done_cnt;
    start_fetch(32'h3, 16'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("t3_npush", 64'(push_q.size() - p0), 64'(1));
    chk("t3_first", 64'(push_q[p0]), 64'(1));
    chk("t3_busy", 64'(busy_o), 64'(1));
    chk("t3_nodone", 64'(done_cnt - d0), 64'(0));
    fifo_full_i = '0;
    wait_idle(200);
    chk("t3_second", 64'(push_q[p0+1]), 64'(0));
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Zero length: done two cycles after start, no request
    a0 = addr_q.size(); d0 = done_cnt;
    start_fetch(32'hFFFF_FFFF, 16'd0);
    wait_idle(50);
    chk("t4_done_cyc", 64'(done_cyc), 64'(ts + 2));
    chk("t4_noreq", 64'(addr_q.size() - a0), 64'(0));
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'(1));

    // FIFO reset while waiting for data; the late rvalid must not push
    set_glb(0, 0, 4, 4);
    p0 = push_q.size(); d0 = done_cnt;
    start_fetch(32'h1, 16'd3);
    n = 0;
    while (!(glb_rd_req_o && glb_rd_gnt_i) && n < 50) begin tick(); n++; end
    chk("t5_gnt_seen", 64'(glb_rd_gnt_i), 64'(1));
    tick();
    fifo_reset_i = 1'b1;
    tick();
    fifo_reset_i = 1'b0;
    chk("t5_busy", 64'(busy_o), 64'(0));
    for (int i = 0; i < 8; i++) tick();
    chk("t5_nopush", 64'(push_q.size() - p0), 64'(0));
    chk("t5_nodone", 64'(done_cnt - d0), 64'(0));
    set_glb(0, 0, 0, 0);
    a0 = addr_q.size();
    start_fetch(32'h1, 16'd1);
    wait_idle(50);
    chk("t5_refetch", 64'(addr_q[a0]), 64'(32'h100));

    // Async reset mid-request, then a start pulse during busy is ignored
    set_glb(10, 10, 0, 0);
    base_addr_i[0] = 32'h300;
    start_fetch(32'h1, 16'd2);
    n = 0;
    while (!glb_rd_req_o && n < 20) begin tick(); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 64'(glb_rd_req_o), 64'(0));
    chk("t6_addr", 64'(glb_rd_addr_o), 64'(0));
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_push", 64'(fifo_push_o), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    set_glb(0, 0, 1, 1);
    a0 = addr_q.size(); p0 = push_q.size();
    start_fetch(32'h1, 16'd2);
    base_addr_i[0] = 32'h500;
    fifo_en_i = 32'h3; fetch_len_i = 16'd5; fetch_start_i = 1'b1;
    tick();
    fetch_start_i = 1'b0;
    wait_idle(100);
    chk("t6_npush", 64'(push_q.size() - p0), 64'(2));
    chk("t6_addr0", 64'(addr_q[a0]), 64'(32'h300));
    chk("t6_addr1", 64'(addr_q[a0+1]), 64'(32'h301));

    // Randomised fetches with full flags, stray starts and occasional aborts
    for (int it = 0; it < 25; it++) begin
      logic [N-1:0] en;
      for (int i = 0; i < N; i++) base_addr_i[i] = $urandom;
      en = (it % 8 == 0) ? '1 : ($urandom & $urandom & $urandom);
      set_glb(0, int'($urandom_range(3, 0)), 0, int'($urandom_range(3, 0)));
      start_fetch(en, LW'($urandom_range(3, 0)));
      n = 0;
      while (busy_o && n < 4000) begin
        fifo_full_i   = ($urandom_range(2, 0) == 0) ? ($urandom & $urandom) : '0;
        fifo_reset_i  = ($urandom_range(299, 0) == 0);
        fetch_start_i = ($urandom_range(19, 0) == 0);
        fetch_len_i   = LW'($urandom_range(3, 0));
        tick();
        fifo_reset_i = 1'b0; fetch_start_i = 1'b0;
        n++;
      end
      fifo_full_i = '0;
      wait_idle(2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
